// File: rtl/cond_exec_if.sv
// Decoder-to-conditional-stage bundle: instruction requests and flags in,
// gated strobes and architectural flags out.
interface cond_exec_if #(
    parameter int COND_W = 3
);
    logic              en;
    logic              valid_in;
    logic [COND_W-1:0] Cond;
    logic [3:0]        ALUFlags;
    logic [1:0]        FlagW;
    logic              PCS;
    logic              RegW;
    logic              MemW;
    logic              NoWrite;
    logic              FlagSave;
    logic              FlagRestore;
    logic              PCSrc;
    logic              RegWrite;
    logic              MemWrite;
    logic              CondEx;
    logic              Squash;
    logic [3:0]        Flags;

    modport master (
        output en, valid_in, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               FlagSave, FlagRestore,
        input  PCSrc, RegWrite, MemWrite, CondEx, Squash, Flags
    );

    modport slave (
        input  en, valid_in, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               FlagSave, FlagRestore,
        output PCSrc, RegWrite, MemWrite, CondEx, Squash, Flags
    );
endinterface

// File: rtl/cond_exec_unit.sv
// Conditional execution stage: NZCV state, condition decode, strobe gating,
// post-branch slot squash and a shadow flag register for exceptions.
module cond_exec_unit #(
    parameter int COND_W      = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    cond_exec_if.slave  bus
);
    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_DEPTH);

    logic [3:0] flags_reg, flags_next;
    logic [3:0] shadow_reg, shadow_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       cond_true;
    logic       squash;
    logic       live;
    logic       cond_ex;
    logic       pc_src;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

    generate
        if (COND_W == 3) begin : g_cond3
            always_comb begin
                cond_true = 1'b0;
                case (bus.Cond)
                    3'd0: cond_true = 1'b1;
                    3'd1: cond_true = z_flag;
                    3'd2: cond_true = ~z_flag;
                    3'd3: cond_true = ~z_flag & (n_flag == v_flag);
                    3'd4: cond_true = (n_flag != v_flag);
                    3'd5: cond_true = (n_flag == v_flag);
                    3'd6: cond_true = z_flag | (n_flag != v_flag);
                    3'd7: cond_true = c_flag;
                    default: cond_true = 1'b0;
                endcase
            end
        end else begin : g_cond4
            always_comb begin
                cond_true = 1'b0;
                case (bus.Cond)
                    4'd0:  cond_true = z_flag;
                    4'd1:  cond_true = ~z_flag;
                    4'd2:  cond_true = c_flag;
                    4'd3:  cond_true = ~c_flag;
                    4'd4:  cond_true = n_flag;
                    4'd5:  cond_true = ~n_flag;
                    4'd6:  cond_true = v_flag;
                    4'd7:  cond_true = ~v_flag;
                    4'd8:  cond_true = c_flag & ~z_flag;
                    4'd9:  cond_true = ~c_flag | z_flag;
                    4'd10: cond_true = (n_flag == v_flag);
                    4'd11: cond_true = (n_flag != v_flag);
                    4'd12: cond_true = ~z_flag & (n_flag == v_flag);
                    4'd13: cond_true = z_flag | (n_flag != v_flag);
                    4'd14: cond_true = 1'b1;
                    default: cond_true = 1'b0;
                endcase
            end
        end
    endgenerate

    // Reset masks everything so a slot presented during reset never escapes.
    assign squash  = (cnt_reg != 4'd0) & ~reset;
    assign live    = bus.valid_in & bus.en & ~squash & ~reset;
    assign cond_ex = live & cond_true;
    assign pc_src  = bus.PCS & cond_ex;

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = pc_src;
    assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.Squash   = squash;
    assign bus.Flags    = flags_reg;

    always_comb begin
        flags_next  = flags_reg;
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        if (bus.en) begin
            if (bus.FlagW[1] & cond_ex) flags_next[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0] & cond_ex) flags_next[1:0] = bus.ALUFlags[1:0];
            // Restore wins over ALU updates; save reads the pre-edge value, so both together swap.
            if (bus.FlagRestore) flags_next  = shadow_reg;
            if (bus.FlagSave)    shadow_next = flags_reg;
            if (pc_src)
                cnt_next = FLUSH_CNT;
            else if (cnt_reg != 4'd0)
                cnt_next = cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg  <= 4'd0;
            shadow_reg <= 4'd0;
            cnt_reg    <= 4'd0;
        end else begin
            flags_reg  <= flags_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
        end
    end
endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit: a 3-bit-condition instance and a
// 4-bit-condition instance sharing clock and reset.
module tb_cond_exec_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cond_exec_if #(.COND_W(3)) if3 ();
    cond_exec_if #(.COND_W(4)) if4 ();

    cond_exec_unit #(.COND_W(3), .FLUSH_DEPTH(2)) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    cond_exec_unit #(.COND_W(4), .FLUSH_DEPTH(2)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if3.en = 1'b1; if3.valid_in = 1'b0; if3.Cond = 3'd0; if3.ALUFlags = 4'd0;
        if3.FlagW = 2'd0; if3.PCS = 1'b0; if3.RegW = 1'b0; if3.MemW = 1'b0;
        if3.NoWrite = 1'b0; if3.FlagSave = 1'b0; if3.FlagRestore = 1'b0;
        if4.en = 1'b1; if4.valid_in = 1'b0; if4.Cond = 4'd14; if4.ALUFlags = 4'd0;
        if4.FlagW = 2'd0; if4.PCS = 1'b0; if4.RegW = 1'b0; if4.MemW = 1'b0;
        if4.NoWrite = 1'b0; if4.FlagSave = 1'b0; if4.FlagRestore = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        if3.valid_in = 1'b1; if3.PCS = 1'b1; if3.RegW = 1'b1; if3.MemW = 1'b1;
        if3.FlagW = 2'b11; if3.ALUFlags = 4'b1111;
        tick(); tick();
        checks++;
        if ({if3.PCSrc, if3.RegWrite, if3.MemWrite, if3.CondEx, if3.Squash} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {if3.PCSrc, if3.RegWrite, if3.MemWrite, if3.CondEx, if3.Squash});
        end
        checks++;
        if (if3.Flags !== 4'b0000) begin
            failures++; $display("FAIL reset_flags3 got=%b want=0000", if3.Flags);
        end
        checks++;
        if (if4.Flags !== 4'b0000) begin
            failures++; $display("FAIL reset_flags4 got=%b want=0000", if4.Flags);
        end
        reset = 1'b0;
        clear_inputs();
        $display("test_reset done");
    endtask

    task automatic test_al_regwrite();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.RegW = 1'b1;
        #1;
        checks++;
        if ({if3.RegWrite, if3.CondEx} !== 2'b11) begin
            failures++; $display("FAIL al_regwrite got=%b want=11", {if3.RegWrite, if3.CondEx});
        end
        checks++;
        if (if3.Flags !== 4'b0000) begin
            failures++; $display("FAIL al_flags got=%b want=0000", if3.Flags);
        end
        if3.NoWrite = 1'b1;
        #1;
        checks++;
        if (if3.RegWrite !== 1'b0) begin
            failures++; $display("FAIL al_nowrite got=%b want=0", if3.RegWrite);
        end
        tick();
        clear_inputs();
        $display("test_al_regwrite done");
    endtask

    task automatic test_flag_forward();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.ALUFlags = 4'b0100; if3.FlagW = 2'b11;
        tick();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd1; if3.MemW = 1'b1;
        #1;
        checks++;
        if (if3.Flags !== 4'b0100) begin
            failures++; $display("FAIL fwd_flags got=%b want=0100", if3.Flags);
        end
        checks++;
        if (if3.MemWrite !== 1'b1) begin
            failures++; $display("FAIL fwd_eq_memwrite got=%b want=1", if3.MemWrite);
        end
        tick();
        // Clear flags, then write only CV with a Z-set ALU result.
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.ALUFlags = 4'b0000; if3.FlagW = 2'b11;
        tick();
        if3.ALUFlags = 4'b0100; if3.FlagW = 2'b01;
        tick();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd1; if3.MemW = 1'b1;
        #1;
        checks++;
        if (if3.Flags !== 4'b0000) begin
            failures++; $display("FAIL cv_only_flags got=%b want=0000", if3.Flags);
        end
        checks++;
        if ({if3.MemWrite, if3.CondEx} !== 2'b00) begin
            failures++; $display("FAIL cv_only_eq got=%b want=00", {if3.MemWrite, if3.CondEx});
        end
        tick();
        clear_inputs();
        $display("test_flag_forward done");
    endtask

    task automatic test_squash();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.PCS = 1'b1;
        #1;
        checks++;
        if (if3.PCSrc !== 1'b1) begin
            failures++; $display("FAIL branch_pcsrc got=%b want=1", if3.PCSrc);
        end
        tick();
        if3.PCS = 1'b0; if3.RegW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({if3.Squash, if3.RegWrite} !== ((i < 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL squash_slot%0d got=%b want=%b", i, {if3.Squash, if3.RegWrite},
                         (i < 2) ? 2'b10 : 2'b01);
            end
            tick();
        end
        clear_inputs();
        $display("test_squash done");
    endtask

    task automatic test_stall();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.PCS = 1'b1;
        tick();
        if3.PCS = 1'b0; if3.RegW = 1'b1; if3.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({if3.Squash, if3.RegWrite, if3.CondEx} !== 3'b100) begin
                failures++;
                $display("FAIL stall_cycle%0d got=%b want=100", i,
                         {if3.Squash, if3.RegWrite, if3.CondEx});
            end
            tick();
        end
        if3.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({if3.Squash, if3.RegWrite} !== ((i < 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL post_stall_slot%0d got=%b want=%b", i, {if3.Squash, if3.RegWrite},
                         (i < 2) ? 2'b10 : 2'b01);
            end
            tick();
        end
        clear_inputs();
        $display("test_stall done");
    endtask

    task automatic test_save_restore();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.FlagW = 2'b11; if3.ALUFlags = 4'b1001;
        tick();
        if3.FlagW = 2'b00; if3.FlagSave = 1'b1;
        tick();
        if3.FlagSave = 1'b0; if3.FlagW = 2'b11; if3.ALUFlags = 4'b0110;
        tick();
        checks++;
        if (if3.Flags !== 4'b0110) begin
            failures++; $display("FAIL after_save_write got=%b want=0110", if3.Flags);
        end
        if3.FlagRestore = 1'b1; if3.ALUFlags = 4'b1111;
        tick();
        checks++;
        if (if3.Flags !== 4'b1001) begin
            failures++; $display("FAIL restore_overrides got=%b want=1001", if3.Flags);
        end
        if3.FlagRestore = 1'b0; if3.ALUFlags = 4'b0011;
        tick();
        if3.FlagW = 2'b00; if3.FlagSave = 1'b1; if3.FlagRestore = 1'b1;
        tick();
        checks++;
        if (if3.Flags !== 4'b1001) begin
            failures++; $display("FAIL swap_flags got=%b want=1001", if3.Flags);
        end
        // A lone restore exposes what the swap put in the shadow.
        if3.FlagSave = 1'b0;
        tick();
        checks++;
        if (if3.Flags !== 4'b0011) begin
            failures++; $display("FAIL swap_shadow got=%b want=0011", if3.Flags);
        end
        clear_inputs();
        $display("test_save_restore done");
    endtask

    task automatic test_cond4();
        clear_inputs();
        if4.valid_in = 1'b1; if4.Cond = 4'd14; if4.FlagW = 2'b11; if4.ALUFlags = 4'b1000;
        tick();
        if4.FlagW = 2'b00;
        if4.Cond = 4'b1011;
        #1;
        checks++;
        if (if4.CondEx !== 1'b1) begin
            failures++; $display("FAIL c4_lt got=%b want=1", if4.CondEx);
        end
        if4.Cond = 4'b1010;
        #1;
        checks++;
        if (if4.CondEx !== 1'b0) begin
            failures++; $display("FAIL c4_ge got=%b want=0", if4.CondEx);
        end
        if4.Cond = 4'b1111;
        #1;
        checks++;
        if (if4.CondEx !== 1'b0) begin
            failures++; $display("FAIL c4_nv got=%b want=0", if4.CondEx);
        end
        if4.Cond = 4'b0100;
        #1;
        checks++;
        if (if4.CondEx !== 1'b1) begin
            failures++; $display("FAIL c4_mi got=%b want=1", if4.CondEx);
        end
        if4.Cond = 4'b0000;
        #1;
        checks++;
        if (if4.CondEx !== 1'b0) begin
            failures++; $display("FAIL c4_eq got=%b want=0", if4.CondEx);
        end
        tick();
        clear_inputs();
        $display("test_cond4 done");
    endtask

    task automatic test_reset_mid_squash();
        clear_inputs();
        if3.valid_in = 1'b1; if3.Cond = 3'd0; if3.PCS = 1'b1;
        tick();
        if3.PCS = 1'b0; if3.RegW = 1'b1;
        tick();
        checks++;
        if (if3.Squash !== 1'b1) begin
            failures++; $display("FAIL mid_squash_cnt1 got=%b want=1", if3.Squash);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({if3.Squash, if3.RegWrite} !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_live got=%b want=01", {if3.Squash, if3.RegWrite});
        end
        tick();
        clear_inputs();
        $display("test_reset_mid_squash done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        test_reset();
        test_al_regwrite();
        test_flag_forward();
        test_squash();
        test_stall();
        test_save_restore();
        test_cond4();
        test_reset_mid_squash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Parametrised successor of the control unit's conditional-logic stage. It holds the NZCV flag state, evaluates the instruction condition field, and gates the PCSrc, RegWrite and MemWrite strobes.
- New over the previous generation:
  - selectable 3-bit or 4-bit condition encoding;
  - a stall enable;
  - automatic squash of FLUSH_DEPTH instruction slots after a taken branch;
  - a shadow flag register with save/restore for exception entry and return.
- Sits between the main decoder and the datapath/PC mux.

Parameters:
- COND_W, 3, condition field width. 3 selects the compact branch encoding; 4 selects the full ARM-style 16-code table.
- FLUSH_DEPTH, 2, number of enabled cycles squashed after a taken branch (0..15; 0 disables squash).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  stage enable; 0 = stall, all state held
- valid_in  in  1  current instruction slot is real
- Cond  in  COND_W  condition field of current instruction
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  2  [1]=update NZ, [0]=update CV
- PCS, RegW, MemW, NoWrite  in  1 each  decoder requests
- FlagSave  in  1  copy Flags into shadow
- FlagRestore  in  1  load Flags from shadow
- PCSrc, RegWrite, MemWrite  out  1 each  gated strobes
- CondEx  out  1  condition passed and slot live
- Squash  out  1  current slot is being killed
- Flags  out  4  architectural {N,Z,C,V}

Behaviour:
- Reset:
  - Flags=0, shadow=0, squash counter=0.
  - While reset=1, PCSrc/RegWrite/MemWrite/CondEx/Squash are all forced 0.
- Condition table for COND_W=3: 000 AL, 001 EQ(Z), 010 NE(~Z), 011 GT(~Z&(N==V)), 100 LT(N!=V), 101 GE(N==V), 110 LE(Z|(N!=V)), 111 CS(C).
- Condition table for COND_W=4: ARM codes 0000 EQ … 1101 LE, 1110 AL; 1111 evaluates false.
- Condition evaluation:
  - Always uses registered Flags; there is no same-cycle bypass.
  - A flag write by instruction i is visible to instruction i+1 on the next enabled cycle.
- Squash and live:
  - Squash = (cnt != 0).
  - live = valid_in & en & ~Squash & ~reset.
  - CondEx = live & condition_true.
- Outputs (combinational, same cycle):
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update at posedge, only when en=1:
  - NZ <= ALUFlags[3:2] if FlagW[1] & CondEx.
  - CV <= ALUFlags[1:0] if FlagW[0] & CondEx.
- Squash counter (4-bit):
  - When en=1 and PCSrc=1: cnt <= FLUSH_DEPTH.
  - Else when en=1 and cnt != 0: cnt <= cnt-1.
  - en=0 holds cnt.
  - Decrement is per enabled cycle, independent of valid_in.
- Branches in squashed slots are ignored: PCSrc=0, so there is no reload.
- Save/restore (evaluated only when en=1; independent of valid_in and Squash):
  - FlagSave alone: shadow <= Flags.
  - FlagRestore alone: Flags <= shadow. This overrides any FlagW update in the same cycle.
  - Both asserted: swap, i.e. Flags <= shadow and shadow <= old Flags.
- Stall: en=0 holds Flags, shadow and cnt, and forces all strobes 0. Squash output still reflects cnt.
- Reset mid-squash clears cnt immediately at that edge; the first post-reset slot is live.
- Implementation budget: ~150-250 lines including both decode tables.

Test Plan:
- Reset then AL (000), RegW=1, valid, en → RegWrite=1, CondEx=1, Flags=0000. NoWrite=1 → RegWrite=0.
- ALUFlags=0100, FlagW=11, AL, then EQ with MemW=1 next cycle → Flags=0100, MemWrite=1. Same sequence with FlagW=01 → Flags=0000, EQ fails, MemWrite=0.
- FLUSH_DEPTH=2: taken branch (AL, PCS=1) → PCSrc=1. Next two enabled slots with RegW=1 → Squash=1, RegWrite=0. Third slot → RegWrite=1.
- Taken branch, then en=0 for 3 cycles, then en=1 → cnt stays 2 during stall; squash covers exactly the next 2 enabled cycles.
- Flags=1001, FlagSave; FlagW=11 with ALUFlags=0110 → Flags=0110. Then FlagRestore with FlagW=11, ALUFlags=1111 → Flags=1001. Then save+restore with shadow=1001, Flags=0011 → Flags=1001, shadow=0011.
- COND_W=4: Flags N=1,V=0, Cond=1011 (LT) → CondEx=1. Cond=1010 (GE) → CondEx=0. Cond=1111 → CondEx=0. Reset asserted during squash cnt=1 → Squash=0 on the next cycle.
